fault_monitor_unit: RTL and testbench
=====================================

// Module: fault_monitor_unit
// PURPOSE
//  Parametrised successor to the single-wire OR of fault flags in the pipeline top.
//  Collects NUM_CH fault sources: IMEM/DMEM s_err/d_err, ALU redundancy fault, mux sticky faults.
//  Keeps per-channel sticky status and saturating event counters, and captures the first fault.
//  Escalates NORMAL -> DEGRADED -> HALT and drives halt_req, which the hazard unit ORs into StallF/StallD.
// PARAMETERS
//  NUM_CH     8      number of fault input channels (1..32)
//  CNT_W      8      per-channel event counter width (saturating)
//  THRESH     4      per-channel count at or above which HALT is entered (1..2^CNT_W-1)
//  FATAL_MASK 8'h0A  bit i=1: any event on channel i forces HALT immediately (e.g. d_err)
//  EDGE_MODE  1      1: count rising edges of fault_in; 0: count every asserted cycle
//  TS_W       16     first-fault timestamp width (free-running cycle counter, saturating)
// PORTS
//  clk            in   1                   system clock, all state on rising edge
//  rst            in   1                   asynchronous, active-low reset
//  fault_in       in   NUM_CH              raw fault flags, sampled each cycle
//  clear_req      in   1                   request to clear the channel(s) selected by clear_all/clear_ch
//  clear_all      in   1                   qualifies clear_req: clear every channel, first-fault and state
//  clear_ch       in   $clog2(NUM_CH)      channel to clear when clear_all=0
//  clear_ack      out  1                   one-cycle pulse, cycle after an accepted clear_req
//  rd_sel         in   $clog2(NUM_CH)      counter readback select
//  rd_count       out  CNT_W               count of channel rd_sel, registered (1-cycle latency)
//  sticky_status  out  NUM_CH              bit i set on any channel-i event, held until cleared
//  any_fault      out  1                   |sticky_status
//  first_valid    out  1                   first-fault record valid
//  first_ch       out  $clog2(NUM_CH)      channel of the first recorded fault
//  first_ts       out  TS_W                timestamp of the first recorded fault
//  mon_state      out  2                   00 NORMAL, 01 DEGRADED, 10 HALT
//  halt_req       out  1                   (mon_state==HALT), registered
// BEHAVIOUR
//  Reset (rst=0, async): all counters, sticky_status, first_*, rd_count, clear_ack = 0.
//   Also at reset: ts counter=0, state NORMAL, halt_req=0, any_fault=0.
//  Event: ev[i] = EDGE_MODE ? fault_in[i] & ~fault_q[i] : fault_in[i].
//   fault_q resets to 0, so a level high at reset release counts once.
//  Counter: cnt[i] <= cnt[i]+1 on ev[i], saturating at 2^CNT_W-1, never wraps.
//   sticky_status[i] <= 1 on the same edge.
//  First fault: when first_valid=0 and any ev, latch the lowest-index active channel and the current ts.
//   first_valid <= 1. Later events do not overwrite.
//  ts: increments every cycle, saturates at all-ones.
//  FSM (registered; effects visible the cycle after the event edge):
//   NORMAL   -> DEGRADED on any ev on a non-fatal channel with the post-update count < THRESH
//   NORMAL/DEGRADED -> HALT on ev[i] with FATAL_MASK[i], or when any post-update cnt >= THRESH
//   HALT has priority over DEGRADED in the same cycle.
//   HALT     -> NORMAL only on accepted clear_all; no other exit
//   DEGRADED -> NORMAL when a single-channel clear leaves sticky_status all zero
//  Clear handshake: clear_req sampled each cycle; accepted unconditionally.
//   Clear takes effect on that edge; clear_ack=1 on the next cycle only.
//   clear_req held high clears every cycle and acks every cycle.
//   clear_all: zero all cnt/sticky, first_valid=0, ts restarts at 0, state NORMAL.
//   clear_ch out of range (>=NUM_CH): no effect, still acked.
//   Single clear zeros cnt/sticky of that channel only. first_* is untouched.
//   Single clear never leaves HALT.
//  Simultaneous clear and ev on the same channel: event wins.
//   cnt=1, sticky=1, first-fault capture still applies.
//   With clear_all, the FSM is re-evaluated from NORMAL with that event.
//  rd_count: registered cnt[rd_sel]; out-of-range rd_sel reads 0.
// STRUCTURE
//  Package fault_mon_pkg: mon_state_t enum (NORMAL, DEGRADED, HALT); channel index localparams
//   (CH_IMEM_S, CH_IMEM_D, CH_DMEM_S, CH_DMEM_D, CH_ALU, CH_MUX ...).
//  Sub-module fault_chan_ctr: one channel (edge detect, saturating counter, sticky, clear).
//   Generate NUM_CH instances. Top holds FSM, first-fault capture, ts, readback mux.
// TESTING
//  1. Reset, no faults, 100 cycles -> mon_state=00, any_fault=0, halt_req=0, first_valid=0.
//  2. EDGE_MODE=1, ch0 held high 10 cycles -> cnt0=1, sticky=8'h01, state DEGRADED.
//     Also first_ch=0, first_ts = cycle of the rise.
//  3. Four separate pulses on ch2 (THRESH=4) -> cnt2=4, halt_req=1 one cycle after the 4th.
//     Then clear_req, clear_ch=2 -> HALT persists and clear_ack pulses.
//  4. Single pulse on ch3 (fatal) -> HALT next cycle.
//     Then clear_req+clear_all -> state NORMAL, all counts 0, first_valid=0, ack 1 cycle later.
//  5. ch5 event same cycle as clear_req, clear_ch=5 -> cnt5=1, sticky[5]=1 (event wins).
//  6. CNT_W=2, 6 pulses on a non-fatal channel with THRESH=3 -> cnt saturates at 3, never 0.
//     Then assert rst mid-burst -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/fault_mon_pkg.sv
// Shared types and channel map for the fault monitor: escalation states,
// fault-source channel indices and small sizing helpers.
package fault_mon_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    DEGRADED = 2'b01,
    HALT     = 2'b10
  } mon_state_t;

  localparam int CH_IMEM_S = 0;
  localparam int CH_IMEM_D = 1;
  localparam int CH_DMEM_S = 2;
  localparam int CH_DMEM_D = 3;
  localparam int CH_ALU    = 4;
  localparam int CH_MUX    = 5;
  localparam int CH_SPARE0 = 6;
  localparam int CH_SPARE1 = 7;

  // Index width that stays legal for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fault_chan_ctr.sv
// One fault channel: optional rising-edge detect, saturating event counter
// and sticky flag, with a per-channel clear that loses to a coincident event.
module fault_chan_ctr #(
  parameter int CNT_W     = 8,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fault_in,
  input  logic             clr,
  output logic             ev,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             sticky,
  output logic             sticky_nxt
);

  logic             fault_q_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sticky_r;
  logic             ev_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             sticky_nxt_s;

  // Event detect and post-update counter/sticky values.
  always_comb begin
    ev_s         = EDGE_MODE ? (fault_in & ~fault_q_r) : fault_in;
    cnt_nxt_s    = cnt_r;
    sticky_nxt_s = sticky_r;
    if (ev_s) begin
      sticky_nxt_s = 1'b1;
      if (clr) begin
        cnt_nxt_s = CNT_W'(1'b1);
      end else if (cnt_r != {CNT_W{1'b1}}) begin
        cnt_nxt_s = cnt_r + CNT_W'(1'b1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (clr) begin
      cnt_nxt_s    = {CNT_W{1'b0}};
      sticky_nxt_s = 1'b0;
    end else begin
      cnt_nxt_s    = cnt_r;
      sticky_nxt_s = sticky_r;
    end
  end

  // Channel state registers; the edge history is not touched by clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      sticky_r  <= 1'b0;
    end else begin
      fault_q_r <= fault_in;
      cnt_r     <= cnt_nxt_s;
      sticky_r  <= sticky_nxt_s;
    end
  end

  assign ev         = ev_s;
  assign cnt        = cnt_r;
  assign cnt_nxt    = cnt_nxt_s;
  assign sticky     = sticky_r;
  assign sticky_nxt = sticky_nxt_s;

endmodule

// File: rtl/fault_monitor_unit.sv
// Fault monitor top: per-channel counters, first-fault capture, free-running
// timestamp, NORMAL/DEGRADED/HALT escalation and registered readback.
module fault_monitor_unit
  import fault_mon_pkg::*;
#(
  parameter int          NUM_CH     = 8,
  parameter int          CNT_W      = 8,
  parameter int          THRESH     = 4,
  parameter logic [31:0] FATAL_MASK = 32'h0000_000A,
  parameter bit          EDGE_MODE  = 1'b1,
  parameter int          TS_W       = 16,
  localparam int         IDX_W      = idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] fault_in,
  input  logic              clear_req,
  input  logic              clear_all,
  input  logic [IDX_W-1:0]  clear_ch,
  output logic              clear_ack,
  input  logic [IDX_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_count,
  output logic [NUM_CH-1:0] sticky_status,
  output logic              any_fault,
  output logic              first_valid,
  output logic [IDX_W-1:0]  first_ch,
  output logic [TS_W-1:0]   first_ts,
  output logic [1:0]        mon_state,
  output logic              halt_req
);

  localparam logic [NUM_CH-1:0] FATAL_C  = FATAL_MASK[NUM_CH-1:0];
  localparam logic [CNT_W-1:0]  THRESH_C = CNT_W'(THRESH);

  logic              clr_all_s;
  logic              clr_one_s;
  logic [NUM_CH-1:0] clr_vec_s;
  logic [NUM_CH-1:0] ev_s;
  logic [NUM_CH-1:0] sticky_s;
  logic [NUM_CH-1:0] sticky_nxt_s;
  logic [CNT_W-1:0]  cnt_s     [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt_s [NUM_CH];

  logic              halt_s;
  logic              degr_s;
  logic              any_ev_s;
  logic [IDX_W-1:0]  first_idx_s;
  mon_state_t        base_s;
  mon_state_t        state_nxt_s;

  mon_state_t        state_r;
  logic              halt_req_r;
  logic              clear_ack_r;
  logic              any_fault_r;
  logic [CNT_W-1:0]  rd_count_r;
  logic [TS_W-1:0]   ts_r;
  logic              first_valid_r;
  logic [IDX_W-1:0]  first_ch_r;
  logic [TS_W-1:0]   first_ts_r;

  assign clr_all_s = clear_req & clear_all;
  assign clr_one_s = clear_req & ~clear_all;

  // Decode the clear request into per-channel clear strobes.
  always_comb begin
    clr_vec_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (clr_all_s || (clr_one_s && (int'(clear_ch) == i))) begin
        clr_vec_s[i] = 1'b1;
      end else begin
        clr_vec_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fault_chan_ctr #(
      .CNT_W     (CNT_W),
      .EDGE_MODE (EDGE_MODE)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst),
      .fault_in   (fault_in[g]),
      .clr        (clr_vec_s[g]),
      .ev         (ev_s[g]),
      .cnt        (cnt_s[g]),
      .cnt_nxt    (cnt_nxt_s[g]),
      .sticky     (sticky_s[g]),
      .sticky_nxt (sticky_nxt_s[g])
    );
  end

  // Escalation causes and lowest-index active channel for first-fault capture.
  always_comb begin
    halt_s      = 1'b0;
    degr_s      = 1'b0;
    any_ev_s    = 1'b0;
    first_idx_s = {IDX_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ev_s[i]) begin
        any_ev_s    = 1'b1;
        first_idx_s = IDX_W'(i);
        if (FATAL_C[i] || (cnt_nxt_s[i] >= THRESH_C)) begin
          halt_s = 1'b1;
        end else begin
          degr_s = 1'b1;
        end
      end else if (cnt_nxt_s[i] >= THRESH_C) begin
        halt_s = 1'b1;
      end else begin
        halt_s = halt_s;
      end
    end
  end

  // Next-state logic; clear_all restarts evaluation from NORMAL.
  always_comb begin
    if (clr_all_s) begin
      base_s = NORMAL;
    end else begin
      base_s = state_r;
    end
    state_nxt_s = base_s;
    case (base_s)
      NORMAL: begin
        if (halt_s) begin
          state_nxt_s = HALT;
        end else if (degr_s) begin
          state_nxt_s = DEGRADED;
        end else begin
          state_nxt_s = NORMAL;
        end
      end
      DEGRADED: begin
        if (halt_s) begin
          state_nxt_s = HALT;
        end else if (clr_one_s && (sticky_nxt_s == {NUM_CH{1'b0}})) begin
          state_nxt_s = NORMAL;
        end else begin
          state_nxt_s = DEGRADED;
        end
      end
      HALT:    state_nxt_s = HALT;
      default: state_nxt_s = HALT;
    endcase
  end

  // State register and the halt request derived from it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= NORMAL;
      halt_req_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      halt_req_r <= (state_nxt_s == HALT);
    end
  end

  // Timestamp, first-fault record, clear handshake and readback registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_r          <= {TS_W{1'b0}};
      first_valid_r <= 1'b0;
      first_ch_r    <= {IDX_W{1'b0}};
      first_ts_r    <= {TS_W{1'b0}};
      clear_ack_r   <= 1'b0;
      any_fault_r   <= 1'b0;
      rd_count_r    <= {CNT_W{1'b0}};
    end else begin
      if (clr_all_s) begin
        ts_r <= {TS_W{1'b0}};
      end else if (ts_r != {TS_W{1'b1}}) begin
        ts_r <= ts_r + TS_W'(1'b1);
      end
      // A clear_all in the same cycle as an event re-arms capture for that event.
      if ((!first_valid_r || clr_all_s) && any_ev_s) begin
        first_valid_r <= 1'b1;
        first_ch_r    <= first_idx_s;
        first_ts_r    <= ts_r;
      end else if (clr_all_s) begin
        first_valid_r <= 1'b0;
      end
      clear_ack_r <= clear_req;
      any_fault_r <= |sticky_nxt_s;
      if (int'(rd_sel) < NUM_CH) begin
        rd_count_r <= cnt_s[rd_sel];
      end else begin
        rd_count_r <= {CNT_W{1'b0}};
      end
    end
  end

  assign clear_ack     = clear_ack_r;
  assign rd_count      = rd_count_r;
  assign sticky_status = sticky_s;
  assign any_fault     = any_fault_r;
  assign first_valid   = first_valid_r;
  assign first_ch      = first_ch_r;
  assign first_ts      = first_ts_r;
  assign mon_state     = state_r;
  assign halt_req      = halt_req_r;

endmodule

// File: tb/tb_fault_monitor_unit.sv
// Bench for fault_monitor_unit: directed vector table, randomized traffic
// against a rule-level reference model, and a narrow-counter saturation/reset test.
module tb_fault_monitor_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (defaults)
  logic        rst;
  logic [7:0]  fault_in;
  logic        clear_req, clear_all;
  logic [2:0]  clear_ch, rd_sel;
  logic        clear_ack;
  logic [7:0]  rd_count, sticky_status;
  logic        any_fault, first_valid, halt_req;
  logic [2:0]  first_ch;
  logic [15:0] first_ts;
  logic [1:0]  mon_state;

  // second DUT: CNT_W=2, THRESH=3
  logic        rst2;
  logic [7:0]  fault_in2;
  logic        clear_req2, clear_all2;
  logic [2:0]  clear_ch2, rd_sel2;
  logic        clear_ack2;
  logic [1:0]  rd_count2;
  logic [7:0]  sticky2;
  logic        any_fault2, first_valid2, halt_req2;
  logic [2:0]  first_ch2;
  logic [15:0] first_ts2;
  logic [1:0]  mon_state2;

  fault_monitor_unit dut (
    .clk(clk), .rst(rst), .fault_in(fault_in), .clear_req(clear_req),
    .clear_all(clear_all), .clear_ch(clear_ch), .clear_ack(clear_ack),
    .rd_sel(rd_sel), .rd_count(rd_count), .sticky_status(sticky_status),
    .any_fault(any_fault), .first_valid(first_valid), .first_ch(first_ch),
    .first_ts(first_ts), .mon_state(mon_state), .halt_req(halt_req)
  );

  fault_monitor_unit #(.CNT_W(2), .THRESH(3)) dut2 (
    .clk(clk), .rst(rst2), .fault_in(fault_in2), .clear_req(clear_req2),
    .clear_all(clear_all2), .clear_ch(clear_ch2), .clear_ack(clear_ack2),
    .rd_sel(rd_sel2), .rd_count(rd_count2), .sticky_status(sticky2),
    .any_fault(any_fault2), .first_valid(first_valid2), .first_ch(first_ch2),
    .first_ts(first_ts2), .mon_state(mon_state2), .halt_req(halt_req2)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  localparam bit [7:0] FATAL = 8'h0A;

  // reference model state
  int       m_cnt [8];
  bit [7:0] m_sticky, m_prev;
  bit       m_fv, m_ack;
  int       m_fch, m_fts, m_ts, m_st, m_rd;

  typedef struct {
    logic [7:0] f;
    logic       cr, ca;
    logic [2:0] cc, rs;
    logic [1:0] st;
    logic [7:0] sk;
    logic       ack, chkrd;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] f, input logic cr, input logic ca,
                              input logic [2:0] cc, input logic [2:0] rs,
                              input logic [1:0] st, input logic [7:0] sk,
                              input logic ack, input logic chkrd, input logic [7:0] rd);
    vec_t v;
    v.f = f; v.cr = cr; v.ca = ca; v.cc = cc; v.rs = rs;
    v.st = st; v.sk = sk; v.ack = ack; v.chkrd = chkrd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_sticky = 8'h00; m_prev = 8'h00; m_fv = 1'b0; m_ack = 1'b0;
    m_fch = 0; m_fts = 0; m_ts = 0; m_st = 0; m_rd = 0;
  endtask

  task automatic model_step();
    bit [7:0] ev;
    bit ca, co, halt, degr, found;
    ev = fault_in & ~m_prev;
    ca = clear_req && clear_all;
    co = clear_req && !clear_all;
    m_rd = m_cnt[rd_sel];
    for (int i = 0; i < 8; i++) begin
      bit cl;
      cl = ca || (co && (clear_ch == i));
      if (ev[i]) begin
        m_cnt[i] = cl ? 1 : ((m_cnt[i] < 255) ? m_cnt[i] + 1 : 255);
        m_sticky[i] = 1'b1;
      end else if (cl) begin
        m_cnt[i] = 0;
        m_sticky[i] = 1'b0;
      end
    end
    if (ca) m_fv = 1'b0;
    if (!m_fv && ev != 8'h00) begin
      found = 1'b0;
      for (int i = 0; i < 8; i++)
        if (ev[i] && !found) begin m_fch = i; found = 1'b1; end
      m_fv = 1'b1;
      m_fts = m_ts;
    end
    if (ca) m_st = 0;
    halt = 1'b0; degr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ev[i] && FATAL[i]) halt = 1'b1;
      if (m_cnt[i] >= 4) halt = 1'b1;
      if (ev[i] && !FATAL[i] && m_cnt[i] < 4) degr = 1'b1;
    end
    if (m_st != 2) begin
      if (halt) m_st = 2;
      else if (m_st == 0 && degr) m_st = 1;
      else if (m_st == 1 && co && m_sticky == 8'h00) m_st = 0;
    end
    m_ts = ca ? 0 : ((m_ts < 65535) ? m_ts + 1 : 65535);
    m_prev = fault_in;
    m_ack = clear_req;
  endtask

  task automatic check_model();
    chk("state", mon_state, m_st);
    chk("halt_req", halt_req, (m_st == 2));
    chk("sticky", sticky_status, m_sticky);
    chk("any_fault", any_fault, (m_sticky != 8'h00));
    chk("first_valid", first_valid, m_fv);
    if (m_fv) begin
      chk("first_ch", first_ch, m_fch);
      chk("first_ts", first_ts, m_fts);
    end
    chk("clear_ack", clear_ack, m_ack);
    chk("rd_count", rd_count, m_rd);
  endtask

  task automatic do_cycle();
    @(posedge clk);
    model_step();
    cyc_cnt++;
    #1;
    check_model();
  endtask

  task automatic cyc2();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rise_ts;
    rst = 1'b0; fault_in = 8'h00; clear_req = 1'b0; clear_all = 1'b0;
    clear_ch = 3'd0; rd_sel = 3'd0;
    rst2 = 1'b0; fault_in2 = 8'h00; clear_req2 = 1'b0; clear_all2 = 1'b0;
    clear_ch2 = 3'd0; rd_sel2 = 3'd0;
    model_reset();
    #20;
    chk("rst_state", mon_state, 2'b00);
    chk("rst_sticky", sticky_status, 8'h00);
    chk("rst_first_valid", first_valid, 1'b0);
    chk("rst_ack", clear_ack, 1'b0);
    chk("rst_rd", rd_count, 8'h00);
    #2;
    rst = 1'b1; rst2 = 1'b1;

    // idle run
    for (int i = 0; i < 100; i++) do_cycle();
    chk("idle_state", mon_state, 2'b00);
    chk("idle_any", any_fault, 1'b0);
    chk("idle_halt", halt_req, 1'b0);
    chk("idle_fv", first_valid, 1'b0);

    // directed table
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(8'h01, 1'b0, 1'b0, 3'd0, 3'd0, 2'd1, 8'h01, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 2'd1, 8'h01, 1'b0, 1'b0, 8'd0));
    for (int p = 0; p < 3; p++) begin
      tbl.push_back(mk(8'h04, 1'b0, 1'b0, 3'd0, 3'd0, 2'd1, 8'h05, 1'b0, 1'b0, 8'd0));
      tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 2'd1, 8'h05, 1'b0, 1'b0, 8'd0));
    end
    tbl.push_back(mk(8'h04, 1'b0, 1'b0, 3'd0, 3'd0, 2'd2, 8'h05, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 3'd2, 2'd2, 8'h05, 1'b0, 1'b1, 8'd4));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, 3'd2, 3'd0, 2'd2, 8'h01, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 3'd2, 2'd2, 8'h01, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h00, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(8'h08, 1'b0, 1'b0, 3'd0, 3'd0, 2'd2, 8'h08, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 2'd2, 8'h08, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 3'd3, 2'd0, 8'h00, 1'b0, 1'b1, 8'd0));
    tbl.push_back(mk(8'h20, 1'b0, 1'b0, 3'd0, 3'd0, 2'd1, 8'h20, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 3'd0, 2'd1, 8'h20, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(8'h20, 1'b1, 1'b0, 3'd5, 3'd0, 2'd1, 8'h20, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 3'd5, 2'd1, 8'h20, 1'b0, 1'b1, 8'd1));
    tbl.push_back(mk(8'h00, 1'b1, 1'b0, 3'd5, 3'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(8'h00, 1'b0, 1'b0, 3'd0, 3'd5, 2'd0, 8'h00, 1'b0, 1'b1, 8'd0));

    rise_ts = cyc_cnt;
    for (int i = 0; i < tbl.size(); i++) begin
      fault_in = tbl[i].f; clear_req = tbl[i].cr; clear_all = tbl[i].ca;
      clear_ch = tbl[i].cc; rd_sel = tbl[i].rs;
      do_cycle();
      chk($sformatf("tbl%0d_state", i), mon_state, tbl[i].st);
      chk($sformatf("tbl%0d_sticky", i), sticky_status, tbl[i].sk);
      chk($sformatf("tbl%0d_ack", i), clear_ack, tbl[i].ack);
      if (tbl[i].chkrd) chk($sformatf("tbl%0d_rd", i), rd_count, tbl[i].rd);
      if (i == 9) begin
        chk("rise_first_ch", first_ch, 3'd0);
        chk("rise_first_ts", first_ts, rise_ts);
      end
    end

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] f;
      f = 8'h00;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(5) == 0) f[b] = 1'b1;
      if ($urandom_range(7) != 0) f = f & ~FATAL;
      fault_in = f;
      clear_req = ($urandom_range(9) == 0);
      clear_all = (m_st == 2) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      clear_ch = 3'($urandom_range(7));
      rd_sel = 3'($urandom_range(7));
      do_cycle();
    end
    fault_in = 8'h00; clear_req = 1'b0; clear_all = 1'b0;

    // narrow counter saturation, then asynchronous reset mid-burst
    for (int k = 0; k < 6; k++) begin
      fault_in2 = 8'h01; cyc2();
      fault_in2 = 8'h00; cyc2();
      chk($sformatf("sat_cnt%0d", k), rd_count2, (k + 1 < 3) ? k + 1 : 3);
      chk($sformatf("sat_state%0d", k), mon_state2, (k + 1 >= 3) ? 2 : 1);
      chk($sformatf("sat_sticky%0d", k), sticky2, 8'h01);
    end
    fault_in2 = 8'h01; clear_req2 = 1'b1; clear_ch2 = 3'd1;
    cyc2();
    chk("pre_rst_ack", clear_ack2, 1'b1);
    chk("pre_rst_halt", halt_req2, 1'b1);
    fault_in2 = 8'h00; clear_req2 = 1'b0;
    #2;
    rst2 = 1'b0;
    #1;
    chk("arst_rd", rd_count2, 2'd0);
    chk("arst_sticky", sticky2, 8'h00);
    chk("arst_any", any_fault2, 1'b0);
    chk("arst_fv", first_valid2, 1'b0);
    chk("arst_fch", first_ch2, 3'd0);
    chk("arst_fts", first_ts2, 16'd0);
    chk("arst_state", mon_state2, 2'b00);
    chk("arst_halt", halt_req2, 1'b0);
    chk("arst_ack", clear_ack2, 1'b0);
    #3;
    rst2 = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
